if_pc_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register.
- Consumes the 28-bit shifted jump field from the jump-target shifter (`jump_target28`) and forms the 32-bit jump address.
- Selects the next PC from sequential, branch, jump and jr sources.
- Handles load-use stalls, control-hazard flushes and halt. Sits between instruction memory and the ID stage.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/next_pc_sel.sv | 53 +++++
 rtl/if_pc_stage.sv | 118 +++++++++++
 tb/tb_if_pc_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and default constants for the MIPS fetch stage.
`timescale 1ns/1ps
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

  typedef enum logic [2:0] {
    SEQ,
    BR,
    J,
    JR,
    EXC
  } npc_sel_t;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_WORD   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

  // Region bits come from the PC+4 of the jump instruction itself.
  function automatic logic [31:0] jump_addr(input logic [3:0]  pc4_hi,
                                            input logic [27:0] target28);
    return {pc4_hi, target28};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux: jr > jump > branch > sequential.
// With PC_ALIGN_CHECK_EN defined a misaligned jr selects the exception vector.
`timescale 1ns/1ps
module next_pc_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [31:0] pc,
  input  logic [3:0]  pc4_hi,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [27:0] jump_target28,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output npc_sel_t    sel,
  output logic [31:0] seq_pc,
  output logic [31:0] next_pc
);

  logic [31:0] jr_addr;
  logic        jr_bad;

  assign seq_pc = pc + 32'd4;

`ifdef PC_ALIGN_CHECK_EN
  assign jr_addr = jr_target;
  assign jr_bad  = (jr_target[1:0] != 2'b00);
`else
  // Without the trap, the low bits are simply dropped.
  assign jr_addr = jr_target & 32'hFFFF_FFFC;
  assign jr_bad  = 1'b0;
`endif

  always_comb begin
    if (jr)                sel = jr_bad ? EXC : JR;
    else if (jump)         sel = J;
    else if (branch_taken) sel = BR;
    else                   sel = SEQ;
  end

  always_comb begin
    case (sel)
      JR:      next_pc = jr_addr;
      J:       next_pc = jump_addr(pc4_hi, jump_target28);
      BR:      next_pc = branch_target;
      EXC:     next_pc = EXC_VECTOR;
      default: next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/if_pc_stage.sv
// MIPS IF stage: PC register, IF/ID pipeline register and BOOT/RUN/HALT fetch FSM.
// Optional misaligned-jr trap (align_err, EXC_VECTOR) enabled by defining PC_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module if_pc_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] NOP_WORD   = DEF_NOP_WORD,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [27:0] jump_target28,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic        align_err
);

  // state | meaning
  // BOOT  | first cycle after reset; pc held, IF/ID bubble
  // RUN   | normal fetch with stall/redirect/flush handling
  // HALT  | pc frozen, IF/ID bubble; left only through reset

  fetch_state_t state;
  npc_sel_t     sel;
  logic [31:0]  next_pc;
  logic [31:0]  seq_pc;
  logic         redirect;

  next_pc_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_pc_sel (
    .pc            (pc),
    .pc4_hi        (ifid_pc4[31:28]),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target28 (jump_target28),
    .jr            (jr),
    .jr_target     (jr_target),
    .sel           (sel),
    .seq_pc        (seq_pc),
    .next_pc       (next_pc)
  );

  assign imem_addr = pc;
  assign redirect  = (sel != SEQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      ifid_instr <= NOP_WORD;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state      <= RUN;
          ifid_instr <= NOP_WORD;
          ifid_valid <= 1'b0;
        end
        RUN: begin
          if (halt) begin
            state      <= HALT;
            halted     <= 1'b1;
            ifid_instr <= NOP_WORD;
            ifid_valid <= 1'b0;
          end else if (!stall) begin
            pc <= next_pc;
            // No delay slot: the wrong-path fetch is squashed, pc4 left as is.
            if (redirect || flush) begin
              ifid_instr <= NOP_WORD;
              ifid_valid <= 1'b0;
            end else begin
              ifid_instr <= imem_rdata;
              ifid_pc4   <= seq_pc;
              ifid_valid <= 1'b1;
            end
          end
        end
        HALT: begin
          halted     <= 1'b1;
          ifid_instr <= NOP_WORD;
          ifid_valid <= 1'b0;
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) align_err <= 1'b0;
    else        align_err <= (state == RUN) && !halt && !stall && (sel == EXC);
  end
`else
  assign align_err = 1'b0;
`endif

  a_one_redirect : assert property (@(posedge clk) disable iff (!rst_n)
    ifid_valid |-> $onehot0({jr, jump, branch_taken}));

endmodule

// File: tb/tb_if_pc_stage.sv
// Bench for if_pc_stage: vector table, hand sequences, and random traffic vs a reference model.
`timescale 1ns/1ps
module tb_if_pc_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall, flush, branch_taken, jump, jr, halt;
  logic [31:0] branch_target, jr_target;
  logic [27:0] jump_target28;
  logic [31:0] pc, ifid_instr, ifid_pc4;
  logic        ifid_valid, halted, align_err;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] EXC = 32'h0000_0080;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state (values expected after the latest edge)
  logic        m_boot, m_halted, m_valid, m_align;
  logic [31:0] m_pc, m_instr, m_pc4;

  if_pc_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target28 (jump_target28),
    .jr            (jr),
    .jr_target     (jr_target),
    .halt          (halt),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .align_err     (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h2008_0005;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic        st, fl, br, jp, jrr, ht;
    logic [31:0] bt, jt;
    logic [27:0] j28;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid, e_halted;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                              input logic jp, input logic [27:0] j28, input logic jrr, input logic [31:0] jt,
                              input logic ht, input logic [31:0] e_pc, input logic e_valid,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_halted);
    vec_t v;
    v.st = st; v.fl = fl; v.br = br; v.bt = bt; v.jp = jp; v.j28 = j28;
    v.jrr = jrr; v.jt = jt; v.ht = ht;
    v.e_pc = e_pc; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_halted = e_halted;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},        pc,                 m_pc);
    chk({tag, ".imem_addr"}, imem_addr,          m_pc);
    chk({tag, ".instr"},     ifid_instr,         m_instr);
    chk({tag, ".pc4"},       ifid_pc4,           m_pc4);
    chk({tag, ".valid"},     {31'd0, ifid_valid}, {31'd0, m_valid});
    chk({tag, ".halted"},    {31'd0, halted},     {31'd0, m_halted});
    chk({tag, ".align_err"}, {31'd0, align_err},  {31'd0, m_align});
  endtask

  task automatic drive(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [27:0] j28, input logic jrr, input logic [31:0] jt,
                       input logic ht);
    stall = st; flush = fl; branch_taken = br; branch_target = bt;
    jump = jp; jump_target28 = j28; jr = jrr; jr_target = jt; halt = ht;
  endtask

  task automatic expect_state(input logic [31:0] e_pc, input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4, input logic e_halted, input logic e_align);
    m_pc = e_pc; m_valid = e_valid; m_instr = e_instr; m_pc4 = e_pc4;
    m_halted = e_halted; m_align = e_align;
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_halted = 1'b0; m_valid = 1'b0; m_align = 1'b0;
    m_pc = 32'd0; m_instr = NOP; m_pc4 = 32'd0;
  endtask

  // One clock edge of the fetch stage, from the architectural rules.
  task automatic model_edge();
    logic [31:0] npc;
    logic        redir;
    m_align = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0; m_instr = NOP; m_valid = 1'b0;
    end else if (m_halted || halt) begin
      m_halted = 1'b1; m_instr = NOP; m_valid = 1'b0;
    end else if (!stall) begin
      redir = jr || jump || branch_taken;
      if (jr) begin
`ifdef PC_ALIGN_CHECK_EN
        if (jr_target % 4 != 0) begin npc = EXC; m_align = 1'b1; end
        else npc = jr_target;
`else
        npc = jr_target - (jr_target % 4);
`endif
      end else if (jump) npc = {m_pc4[31:28], jump_target28};
      else if (branch_taken) npc = branch_target;
      else npc = m_pc + 32'd4;
      if (redir || flush) begin
        m_instr = NOP; m_valid = 1'b0;
      end else begin
        m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      m_pc = npc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge: pulses reset mid-cycle and checks the async clear.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2 rst_n = 1'b1;
  endtask

  vec_t vq[$];

  initial begin
    int          r;
    logic [31:0] tmp;
    logic [31:0] t_jr;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //            st fl br bt            jp j28           jr jt     ht  pc             v  instr                       pc4            h
    vq.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,      0, 32'h0,         0, NOP,                        32'h0,         0));
    vq.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,      0, 32'h4,         1, 32'h2008_0005,              32'h4,         0));
    vq.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,      0, 32'h8,         1, mem_word(32'h4),            32'h8,         0));
    vq.push_back(mk(0, 0, 1, 32'h1000_000C, 0, 0,           0, 0,      0, 32'h1000_000C, 0, NOP,                        32'h8,         0));
    vq.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,      0, 32'h1000_0010, 1, mem_word(32'h1000_000C),    32'h1000_0010, 0));
    vq.push_back(mk(0, 0, 0, 0,            1, 28'h000_0040, 0, 0,      0, 32'h1000_0040, 0, NOP,                        32'h1000_0010, 0));
    vq.push_back(mk(0, 0, 1, 32'h300,      1, 28'h000_0998, 1, 32'h200, 0, 32'h200,      0, NOP,                        32'h1000_0010, 0));
    vq.push_back(mk(1, 0, 1, 32'h80,       0, 0,            0, 0,      0, 32'h200,       0, NOP,                        32'h1000_0010, 0));
    vq.push_back(mk(0, 0, 1, 32'h80,       0, 0,            0, 0,      0, 32'h80,        0, NOP,                        32'h1000_0010, 0));
    vq.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,      0, 32'h84,        1, mem_word(32'h80),           32'h84,        0));
    vq.push_back(mk(1, 1, 0, 0,            0, 0,            0, 0,      0, 32'h84,        1, mem_word(32'h80),           32'h84,        0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0,      0, 32'h88,        0, NOP,                        32'h84,        0));
    vq.push_back(mk(0, 0, 1, 32'h500,      1, 28'h000_0100, 0, 0,      0, 32'h100,       0, NOP,                        32'h84,        0));
    vq.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0,           0, 0,      0, 32'hFFFF_FFFC, 0, NOP,                        32'h84,        0));
    vq.push_back(mk(0, 0, 0, 0,            1, 28'h000_0200, 0, 0,      0, 32'h200,       0, NOP,                        32'h84,        0));
    vq.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0,           0, 0,      0, 32'hFFFF_FFFC, 0, NOP,                        32'h84,        0));
    vq.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,      0, 32'h0,         1, mem_word(32'hFFFF_FFFC),    32'h0,         0));
    vq.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,      0, 32'h4,         1, 32'h2008_0005,              32'h4,         0));
    vq.push_back(mk(0, 0, 0, 0,            1, 28'h000_0400, 0, 0,      1, 32'h4,         0, NOP,                        32'h4,         1));
    vq.push_back(mk(0, 0, 1, 32'h40,       0, 0,            0, 0,      0, 32'h4,         0, NOP,                        32'h4,         1));
    vq.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,      0, 32'h4,         0, NOP,                        32'h4,         1));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].st, vq[i].fl, vq[i].br, vq[i].bt, vq[i].jp, vq[i].j28, vq[i].jrr, vq[i].jt, vq[i].ht);
      tick();
      expect_state(vq[i].e_pc, vq[i].e_valid, vq[i].e_instr, vq[i].e_pc4, vq[i].e_halted, 1'b0);
      check_all($sformatf("vec%0d", i));
    end

    // Reset out of HALT, then a jr to a misaligned target.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset("halt_rst");
    tick();
    expect_state(32'h0, 0, NOP, 32'h0, 0, 0);
    check_all("boot");
    tick();
    expect_state(32'h4, 1, 32'h2008_0005, 32'h4, 0, 0);
    check_all("first_fetch");
    drive(0, 0, 0, 0, 0, 0, 1, 32'h0000_0102, 0);
`ifdef PC_ALIGN_CHECK_EN
    t_jr = EXC;
    tick();
    expect_state(t_jr, 0, NOP, 32'h4, 0, 1);
`else
    t_jr = 32'h100;
    tick();
    expect_state(t_jr, 0, NOP, 32'h4, 0, 0);
`endif
    check_all("jr_misaligned");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_state(t_jr + 32'd4, 1, mem_word(t_jr), t_jr + 32'd4, 0, 0);
    check_all("jr_target_fetch");

    // Random traffic against the model.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset("rnd_rst0");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($sformatf("rnd_rst%0d", i));
      end
      r = $urandom_range(0, 9);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      halt  = ($urandom_range(0, 199) == 0);
      jr = (r == 1); jump = (r == 2); branch_taken = (r == 3) || (r == 6);
      if (!m_valid && r == 4) begin jr = 1'b1; jump = 1'b1; branch_taken = 1'b1; end
      if (!m_valid && r == 5) begin jump = 1'b1; branch_taken = 1'b1; end
      tmp = $urandom;
      branch_target = (r == 6) ? 32'hFFFF_FFF8 : (tmp & 32'hFFFF_FFFC);
      tmp = $urandom;
      jump_target28 = {tmp[25:0], 2'b00};
      tmp = $urandom;
      jr_target = ($urandom_range(0, 3) == 0) ? tmp : (tmp & 32'hFFFF_FFFC);
      model_edge();
      tick();
      check_all($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
